// File: rtl/bus_pkg.sv
// Shared bus definitions: data width and the source codes used by the bus mux,
// register file and control unit.
package bus_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NUM_SRC = 24;
  localparam int unsigned SEL_W   = 5;

  localparam logic [SEL_W-1:0] SRC_R0     = 5'd0;
  localparam logic [SEL_W-1:0] SRC_R1     = 5'd1;
  localparam logic [SEL_W-1:0] SRC_R2     = 5'd2;
  localparam logic [SEL_W-1:0] SRC_R3     = 5'd3;
  localparam logic [SEL_W-1:0] SRC_R4     = 5'd4;
  localparam logic [SEL_W-1:0] SRC_R5     = 5'd5;
  localparam logic [SEL_W-1:0] SRC_R6     = 5'd6;
  localparam logic [SEL_W-1:0] SRC_R7     = 5'd7;
  localparam logic [SEL_W-1:0] SRC_R8     = 5'd8;
  localparam logic [SEL_W-1:0] SRC_R9     = 5'd9;
  localparam logic [SEL_W-1:0] SRC_R10    = 5'd10;
  localparam logic [SEL_W-1:0] SRC_R11    = 5'd11;
  localparam logic [SEL_W-1:0] SRC_R12    = 5'd12;
  localparam logic [SEL_W-1:0] SRC_R13    = 5'd13;
  localparam logic [SEL_W-1:0] SRC_R14    = 5'd14;
  localparam logic [SEL_W-1:0] SRC_R15    = 5'd15;
  localparam logic [SEL_W-1:0] SRC_HI     = 5'd16;
  localparam logic [SEL_W-1:0] SRC_LO     = 5'd17;
  localparam logic [SEL_W-1:0] SRC_ZHIGH  = 5'd18;
  localparam logic [SEL_W-1:0] SRC_ZLOW   = 5'd19;
  localparam logic [SEL_W-1:0] SRC_PC     = 5'd20;
  localparam logic [SEL_W-1:0] SRC_MDR    = 5'd21;
  localparam logic [SEL_W-1:0] SRC_INPORT = 5'd22;
  localparam logic [SEL_W-1:0] SRC_C      = 5'd23;

endpackage

// File: rtl/src_encoder.sv
// Priority encoder for the bus out-enables: lowest set index wins, plus
// any/multiple-enable indications for idle and conflict handling.
module src_encoder
  import bus_pkg::*;
(
  input  logic [NUM_SRC-1:0] en,
  output logic [SEL_W-1:0]   sel,
  output logic               any_en,
  output logic               multi_en
);

  localparam logic [NUM_SRC-1:0] One = {{(NUM_SRC-1){1'b0}}, 1'b1};

  always_comb begin
    sel = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (en[i]) sel = SEL_W'(i);
    end
  end

  assign any_en   = |en;
  // Clearing the lowest set bit leaves something only if 2+ bits were set.
  assign multi_en = |(en & (en - One));

endmodule

// File: rtl/bus_source_mux.sv
// Read side of the datapath bus: encodes the out-enables, registers the chosen
// source word onto the bus and tracks multi-driver conflicts.
module bus_source_mux #(
  parameter int unsigned DATA_W    = bus_pkg::DATA_W,
  parameter int unsigned N_SRC     = bus_pkg::NUM_SRC,
  parameter int unsigned HOLD_IDLE = 1,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 clr,
  input  logic [15:0]          r_out,
  input  logic                 hi_out,
  input  logic                 lo_out,
  input  logic                 zhi_out,
  input  logic                 zlo_out,
  input  logic                 pc_out,
  input  logic                 mdr_out,
  input  logic                 inport_out,
  input  logic                 c_out,
  input  logic [16*DATA_W-1:0] reg_data,
  input  logic [DATA_W-1:0]    hi_data,
  input  logic [DATA_W-1:0]    lo_data,
  input  logic [DATA_W-1:0]    zhi_data,
  input  logic [DATA_W-1:0]    zlo_data,
  input  logic [DATA_W-1:0]    pc_data,
  input  logic [DATA_W-1:0]    mdr_data,
  input  logic [DATA_W-1:0]    inport_data,
  input  logic [DATA_W-1:0]    c_sign_ext,
  input  logic                 conflict_clr,
  output logic [DATA_W-1:0]    bus_mux_out,
  output logic                 bus_valid,
  output logic [4:0]           bus_sel,
  output logic                 conflict,
  output logic [CNT_W-1:0]     conflict_cnt
);

  import bus_pkg::*;

  localparam logic [CNT_W-1:0] CntMax = {CNT_W{1'b1}};

  logic [N_SRC-1:0]  src_en;
  logic [SEL_W-1:0]  enc_sel;
  logic              any_en;
  logic              multi_en;
  logic [DATA_W-1:0] reg_word [16];
  logic [DATA_W-1:0] sel_data;

  logic [DATA_W-1:0] bus_d, bus_q;
  logic [SEL_W-1:0]  sel_d, sel_q;
  logic              valid_d, valid_q;
  logic              conf_d, conf_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  // Bit order matches the source codes, so the enable index is the code.
  assign src_en = {c_out, inport_out, mdr_out, pc_out, zlo_out, zhi_out, lo_out, hi_out, r_out};

  src_encoder u_src_encoder (
    .en       (src_en),
    .sel      (enc_sel),
    .any_en   (any_en),
    .multi_en (multi_en)
  );

  for (genvar i = 0; i < 16; i++) begin : g_reg_word
    assign reg_word[i] = reg_data[i*DATA_W +: DATA_W];
  end

  always_comb begin
    sel_data = reg_word[enc_sel[3:0]];
    case (enc_sel)
      SRC_HI:     sel_data = hi_data;
      SRC_LO:     sel_data = lo_data;
      SRC_ZHIGH:  sel_data = zhi_data;
      SRC_ZLOW:   sel_data = zlo_data;
      SRC_PC:     sel_data = pc_data;
      SRC_MDR:    sel_data = mdr_data;
      SRC_INPORT: sel_data = inport_data;
      SRC_C:      sel_data = c_sign_ext;
      default:    sel_data = reg_word[enc_sel[3:0]];
    endcase
  end

  always_comb begin
    bus_d   = bus_q;
    sel_d   = sel_q;
    valid_d = 1'b0;
    if (any_en) begin
      bus_d   = sel_data;
      sel_d   = enc_sel;
      valid_d = 1'b1;
    end else if (HOLD_IDLE == 0) begin
      bus_d = '0;
    end
  end

  // A clear in the same cycle as a conflict discards that conflict entirely.
  always_comb begin
    conf_d = conf_q;
    cnt_d  = cnt_q;
    if (conflict_clr) begin
      conf_d = 1'b0;
      cnt_d  = '0;
    end else if (multi_en) begin
      conf_d = 1'b1;
      if (cnt_q != CntMax) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      bus_q   <= '0;
      sel_q   <= '0;
      valid_q <= 1'b0;
      conf_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      bus_q   <= bus_d;
      sel_q   <= sel_d;
      valid_q <= valid_d;
      conf_q  <= conf_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus_mux_out  = bus_q;
  assign bus_sel      = sel_q;
  assign bus_valid    = valid_q;
  assign conflict     = conf_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_bus_source_mux.sv
// Bench for bus_source_mux: directed scenarios plus randomized traffic compared
// against a source-level model, with a HOLD_IDLE=1 and a HOLD_IDLE=0 instance.
module tb_bus_source_mux;

  logic         clk = 1'b0;
  logic         clr = 1'b0;
  logic         conflict_clr = 1'b0;
  logic [23:0]  en_v = '0;
  logic [31:0]  dat [24];
  logic [511:0] reg_data;

  logic [31:0] bus_h, bus_z;
  logic        valid_h, valid_z;
  logic [4:0]  sel_h, sel_z;
  logic        conf_h, conf_z;
  logic [7:0]  cnt_h, cnt_z;

  int checks = 0;
  int errors = 0;

  // Reference state
  logic [31:0] exp_bus_h, exp_bus_z;
  logic [4:0]  exp_sel;
  logic        exp_valid, exp_conf;
  int          exp_cnt;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < 16; i++) reg_data[i*32 +: 32] = dat[i];
  end

  bus_source_mux #(.HOLD_IDLE(1)) dut (
    .clk(clk), .clr(clr), .r_out(en_v[15:0]),
    .hi_out(en_v[16]), .lo_out(en_v[17]), .zhi_out(en_v[18]), .zlo_out(en_v[19]),
    .pc_out(en_v[20]), .mdr_out(en_v[21]), .inport_out(en_v[22]), .c_out(en_v[23]),
    .reg_data(reg_data), .hi_data(dat[16]), .lo_data(dat[17]), .zhi_data(dat[18]),
    .zlo_data(dat[19]), .pc_data(dat[20]), .mdr_data(dat[21]), .inport_data(dat[22]),
    .c_sign_ext(dat[23]), .conflict_clr(conflict_clr),
    .bus_mux_out(bus_h), .bus_valid(valid_h), .bus_sel(sel_h),
    .conflict(conf_h), .conflict_cnt(cnt_h)
  );

  bus_source_mux #(.HOLD_IDLE(0)) dut_z (
    .clk(clk), .clr(clr), .r_out(en_v[15:0]),
    .hi_out(en_v[16]), .lo_out(en_v[17]), .zhi_out(en_v[18]), .zlo_out(en_v[19]),
    .pc_out(en_v[20]), .mdr_out(en_v[21]), .inport_out(en_v[22]), .c_out(en_v[23]),
    .reg_data(reg_data), .hi_data(dat[16]), .lo_data(dat[17]), .zhi_data(dat[18]),
    .zlo_data(dat[19]), .pc_data(dat[20]), .mdr_data(dat[21]), .inport_data(dat[22]),
    .c_sign_ext(dat[23]), .conflict_clr(conflict_clr),
    .bus_mux_out(bus_z), .bus_valid(valid_z), .bus_sel(sel_z),
    .conflict(conf_z), .conflict_cnt(cnt_z)
  );

  // Model: the lowest-numbered asserted source drives; 2+ drivers is a conflict.
  task automatic tick();
    int n;
    int w;
    @(posedge clk);
    n = 0;
    w = -1;
    for (int i = 23; i >= 0; i--) begin
      if (en_v[i]) begin
        n++;
        w = i;
      end
    end
    if (clr) begin
      exp_bus_h = '0; exp_bus_z = '0; exp_sel = '0; exp_valid = 1'b0;
      exp_conf = 1'b0; exp_cnt = 0;
    end else begin
      if (n > 0) begin
        exp_bus_h = dat[w];
        exp_bus_z = dat[w];
        exp_sel   = 5'(w);
        exp_valid = 1'b1;
      end else begin
        exp_bus_z = '0;
        exp_valid = 1'b0;
      end
      if (conflict_clr) begin
        exp_conf = 1'b0;
        exp_cnt  = 0;
      end else if (n >= 2) begin
        exp_conf = 1'b1;
        if (exp_cnt < 255) exp_cnt++;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    en_v = 24'h000001;
    dat[0] = 32'hDEAD_BEEF;
    clr = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus_h, sel_h, valid_h, conf_h, cnt_h} !== 47'd0) begin
      errors++;
      $display("FAIL reset_outputs got bus=%h sel=%0d v=%b c=%b cnt=%0d want all 0",
               bus_h, sel_h, valid_h, conf_h, cnt_h);
    end
    checks++;
    if ({bus_z, sel_z, valid_z, conf_z, cnt_z} !== 47'd0) begin
      errors++;
      $display("FAIL reset_outputs_z got bus=%h sel=%0d v=%b want all 0", bus_z, sel_z, valid_z);
    end
    clr = 1'b0;
    tick();
    checks++;
    if (bus_h !== 32'hDEAD_BEEF || sel_h !== 5'd0 || valid_h !== 1'b1) begin
      errors++;
      $display("FAIL reset_release got bus=%h sel=%0d v=%b want deadbeef 0 1",
               bus_h, sel_h, valid_h);
    end
  endtask

  task automatic test_sweep();
    for (int k = 0; k < 24; k++) begin
      en_v = 24'(1) << k;
      dat[k] = 32'h1000_0000 + 32'(k);
      tick();
      checks++;
      if (bus_h !== 32'h1000_0000 + 32'(k) || sel_h !== 5'(k) || valid_h !== 1'b1
          || conf_h !== 1'b0) begin
        errors++;
        $display("FAIL sweep_%0d got bus=%h sel=%0d v=%b c=%b want %h %0d 1 0",
                 k, bus_h, sel_h, valid_h, conf_h, 32'h1000_0000 + 32'(k), k);
      end
    end
  endtask

  task automatic test_idle_hold();
    en_v = 24'h000020;
    dat[5] = 32'h0000_0055;
    tick();
    en_v = '0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus_h !== 32'h55 || valid_h !== 1'b0 || sel_h !== 5'd5) begin
        errors++;
        $display("FAIL idle_hold_%0d got bus=%h v=%b sel=%0d want 55 0 5",
                 i, bus_h, valid_h, sel_h);
      end
      checks++;
      if (bus_z !== 32'h0 || valid_z !== 1'b0) begin
        errors++;
        $display("FAIL idle_zero_%0d got bus=%h v=%b want 0 0", i, bus_z, valid_z);
      end
    end
  endtask

  task automatic test_conflict();
    en_v = '0;
    en_v[3] = 1'b1;
    en_v[20] = 1'b1;
    dat[3] = 32'h3333_3333;
    dat[20] = 32'h2020_2020;
    tick();
    checks++;
    if (bus_h !== 32'h3333_3333 || sel_h !== 5'd3 || conf_h !== 1'b1 || cnt_h !== 8'd1) begin
      errors++;
      $display("FAIL conflict_first got bus=%h sel=%0d c=%b cnt=%0d want 33333333 3 1 1",
               bus_h, sel_h, conf_h, cnt_h);
    end
    for (int i = 1; i < 300; i++) tick();
    checks++;
    if (cnt_h !== 8'd255 || conf_h !== 1'b1) begin
      errors++;
      $display("FAIL conflict_saturate got cnt=%0d c=%b want 255 1", cnt_h, conf_h);
    end
  endtask

  task automatic test_clear_collision();
    conflict_clr = 1'b1;
    tick();
    conflict_clr = 1'b0;
    checks++;
    if (conf_h !== 1'b0 || cnt_h !== 8'd0) begin
      errors++;
      $display("FAIL clear_collision got c=%b cnt=%0d want 0 0", conf_h, cnt_h);
    end
    tick();
    checks++;
    if (conf_h !== 1'b1 || cnt_h !== 8'd1) begin
      errors++;
      $display("FAIL clear_then_count got c=%b cnt=%0d want 1 1", conf_h, cnt_h);
    end
  endtask

  task automatic test_mid_reset();
    en_v = 24'h800000;
    dat[23] = 32'hFFFF_FFF0;
    clr = 1'b1;
    tick();
    checks++;
    if (bus_h !== 32'h0 || valid_h !== 1'b0 || conf_h !== 1'b0 || cnt_h !== 8'd0) begin
      errors++;
      $display("FAIL mid_reset got bus=%h v=%b c=%b cnt=%0d want 0 0 0 0",
               bus_h, valid_h, conf_h, cnt_h);
    end
    clr = 1'b0;
    tick();
    checks++;
    if (bus_h !== 32'hFFFF_FFF0 || sel_h !== 5'd23 || valid_h !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_resume got bus=%h sel=%0d v=%b want fffffff0 23 1",
               bus_h, sel_h, valid_h);
    end
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      en_v = '0;
      repeat ($urandom_range(0, 3)) en_v[$urandom_range(0, 23)] = 1'b1;
      for (int i = 0; i < 24; i++) dat[i] = $urandom;
      clr = ($urandom_range(0, 24) == 0);
      conflict_clr = ($urandom_range(0, 14) == 0);
      tick();
      checks++;
      if (bus_h !== exp_bus_h || sel_h !== exp_sel || valid_h !== exp_valid
          || conf_h !== exp_conf || cnt_h !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL random_%0d got bus=%h sel=%0d v=%b c=%b cnt=%0d want %h %0d %b %b %0d",
                 c, bus_h, sel_h, valid_h, conf_h, cnt_h,
                 exp_bus_h, exp_sel, exp_valid, exp_conf, exp_cnt);
      end
      checks++;
      if (bus_z !== exp_bus_z || valid_z !== exp_valid) begin
        errors++;
        $display("FAIL random_z_%0d got bus=%h v=%b want %h %b",
                 c, bus_z, valid_z, exp_bus_z, exp_valid);
      end
    end
    clr = 1'b0;
    conflict_clr = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 24; i++) dat[i] = '0;
    exp_bus_h = '0; exp_bus_z = '0; exp_sel = '0;
    exp_valid = 1'b0; exp_conf = 1'b0; exp_cnt = 0;
    test_reset();
    test_sweep();
    test_idle_hold();
    test_conflict();
    test_clear_collision();
    test_mid_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/bus_source_mux.md
Name: bus_source_mux

Overview:
- Read side of the 32-bit datapath bus: selects one of 24 sources (R0–R15, HI, LO, Zhigh, Zlow, PC, MDR, InPort, C) and drives the shared bus value consumed by the register file and the other bus sinks.
- One-hot out-enables are encoded to a 5-bit source code. The selected word is registered onto the bus with 1-cycle latency.
- Multi-driver conflicts are detected, resolved by priority, flagged sticky and counted.

Parameters:
- DATA_W, 32, bus word width
- N_SRC, 24, number of bus sources (fixed encoding below)
- HOLD_IDLE, 1, 1 = bus holds last value when no enable is asserted; 0 = bus drives 0
- CNT_W, 8, width of the saturating conflict counter

Ports:
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high reset
- r_out  in  16  per-register out-enables, bit i = Ri
- hi_out, lo_out, zhi_out, zlo_out, pc_out, mdr_out, inport_out, c_out  in  1 each  special-source out-enables
- reg_data  in  16*DATA_W  packed register contents, Ri at [i*DATA_W +: DATA_W]
- hi_data, lo_data, zhi_data, zlo_data, pc_data, mdr_data, inport_data  in  DATA_W each  special-source contents
- c_sign_ext  in  DATA_W  sign-extended immediate
- conflict_clr  in  1  clears sticky flag and counter
- bus_mux_out  out  DATA_W  registered bus value
- bus_valid  out  1  high when bus_mux_out was loaded from an asserted source on the previous edge
- bus_sel  out  5  registered source code of the current bus value
- conflict  out  1  sticky: 2+ enables were seen since the last clear
- conflict_cnt  out  CNT_W  saturating count of conflict cycles

Behaviour:
- Source codes: R0–R15 = 0–15, HI = 16, LO = 17, Zhigh = 18, Zlow = 19, PC = 20, MDR = 21, InPort = 22, C = 23. Codes 24–31 are unused.
- Encoding: form a 24-bit enable vector. The lowest set index wins (priority encoder).
- Register stage: on each rising edge where clr = 0:
  - any enable set: bus_mux_out <= data[winner], bus_sel <= winner, bus_valid <= 1.
  - no enable set: bus_valid <= 0, bus_sel unchanged. bus_mux_out is unchanged if HOLD_IDLE = 1, else 0.
- Latency: exactly 1 cycle from enable/data to bus_mux_out. Data is sampled on the same edge as the enables.
- Conflict detection: popcount(enable vector) >= 2 in a cycle sets conflict <= 1 and increments conflict_cnt. The counter saturates at 2^CNT_W − 1 and does not wrap. The winning source is still driven by priority.
- conflict_clr and a conflict in the same cycle: clear wins for the flag; counter loads 0 (that cycle's conflict is not counted).
- Reset (clr = 1, synchronous, overrides all other inputs):
  - bus_mux_out = 0, bus_sel = 0, bus_valid = 0, conflict = 0, conflict_cnt = 0.
  - Reset asserted mid-sequence discards that cycle's selection. The first selection after release appears one edge after the enable.
- No combinational path from any input to any output.

Decomposition:
- Shared package bus_pkg: DATA_W, the source-code constants (SRC_R0 … SRC_C), NUM_SRC = 24, SEL_W = 5. The register file and control unit use the same codes.
- One sub-module, src_encoder (combinational):
  - input: 24-bit enable vector
  - outputs: 5-bit winner code, any_en, multi_en
- Top level holds the data mux, output registers and conflict logic.

Test Plan:
- Reset: clr = 1 for 2 cycles with r_out = 16'h0001 and reg_data R0 = 32'hDEAD_BEEF → all outputs 0. Release clr → next edge: bus_mux_out = 32'hDEAD_BEEF, bus_sel = 0, bus_valid = 1.
- Sweep: one-hot each of the 24 sources in turn, source k data = 32'h1000_0000 + k → each value appears one cycle later with bus_sel = k; conflict stays 0.
- Idle hold: drive R5 = 32'h0000_0055 for 1 cycle, then no enables for 3 cycles.
  - HOLD_IDLE = 1 → bus holds 32'h55 with bus_valid = 0.
  - HOLD_IDLE = 0 → bus = 0 after the idle edge.
- Conflict: r_out[3] = 1 and pc_out = 1 together, R3 = 32'h3333_3333 → bus = 32'h3333_3333, bus_sel = 3, conflict = 1, conflict_cnt = 1. Repeat 300 cycles → conflict_cnt saturates at 255.
- Clear collision: conflict_clr = 1 in the same cycle as a double enable → conflict = 0, conflict_cnt = 0.
- Mid-stream reset: C source = 32'hFFFF_FFF0 enabled, clr pulsed high on the same edge → bus_mux_out = 0, bus_valid = 0. The value appears only after re-enable with clr = 0.
